wwd_output_queue: RTL and testbench

WWD_OUTPUT_QUEUE -- requirements
Module: wwd_output_queue

---
 rtl/wwd_output_queue.sv | 113 +++++++++++
 tb/tb_wwd_output_queue.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wwd_output_queue.sv
// Output queue between CPU WWD retirements and the LED/output_port display.
// Buffers WWD results in a circular FIFO and shows them one at a time, timed or stepped.
module wwd_output_queue #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     reset_cpu_n,
  input  logic                     wwd_valid,
  input  logic [15:0]              wwd_data,
  input  logic [7:0]               wwd_pc,
  input  logic                     auto_mode,
  input  logic                     step,
  input  logic                     clear_ovf,
  output logic [15:0]              disp_data,
  output logic [7:0]               disp_pc,
  output logic                     disp_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     cpu_stall,
  output logic                     overflow,
  output logic                     state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(HOLD_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [23:0]   mem [DEPTH];
  logic          release_now;
  logic          pop;
  logic          push;
  logic          drop;

  // Pop decisions use the pre-edge count, so a same-cycle push into an empty
  // queue is never shown until the following cycle.
  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    release_now = 1'b0;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          timer_nxt = '0;
          state_nxt = SHOW;
        end
      end
      SHOW: begin
        // Timer saturates so a long manual hold never wraps into a false auto release.
        if (timer != TIMER_LAST) timer_nxt = timer + TW'(1);
        release_now = auto_mode ? (timer == TIMER_LAST) : step;
        if (release_now) begin
          timer_nxt = '0;
          if (count != '0) pop = 1'b1;
          else             state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign push       = wwd_valid && ((count != COUNT_FULL) || pop);
  assign drop       = wwd_valid && !push;
  assign cpu_stall  = (count == COUNT_FULL);
  assign disp_valid = (state == SHOW);
  assign state_dbg  = (state == SHOW);

  always_ff @(posedge clk or negedge reset_cpu_n) begin
    if (!reset_cpu_n) begin
      state     <= IDLE;
      timer     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      disp_data <= '0;
      disp_pc   <= '0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        disp_data <= mem[rd_ptr][23:8];
        disp_pc   <= mem[rd_ptr][7:0];
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

  // Storage is not reset; the pointers/count guarantee only written entries are read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wwd_data, wwd_pc};
  end

endmodule

// File: tb/tb_wwd_output_queue.sv
// Directed bench for wwd_output_queue (DEPTH=4, HOLD_CYCLES=8).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_wwd_output_queue;

  logic        clk = 1'b0;
  logic        reset_cpu_n = 1'b0;
  logic        wwd_valid = 1'b0;
  logic [15:0] wwd_data = '0;
  logic [7:0]  wwd_pc = '0;
  logic        auto_mode = 1'b0;
  logic        step = 1'b0;
  logic        clear_ovf = 1'b0;
  logic [15:0] disp_data;
  logic [7:0]  disp_pc;
  logic        disp_valid;
  logic [2:0]  count;
  logic        cpu_stall;
  logic        overflow;
  logic        state_dbg;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  wwd_output_queue #(.DEPTH(4), .HOLD_CYCLES(8)) dut (
    .clk(clk), .reset_cpu_n(reset_cpu_n), .wwd_valid(wwd_valid), .wwd_data(wwd_data),
    .wwd_pc(wwd_pc), .auto_mode(auto_mode), .step(step), .clear_ovf(clear_ovf),
    .disp_data(disp_data), .disp_pc(disp_pc), .disp_valid(disp_valid), .count(count),
    .cpu_stall(cpu_stall), .overflow(overflow), .state_dbg(state_dbg)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [15:0] d, input logic [7:0] p);
    wwd_valid = 1'b1;
    wwd_data  = d;
    wwd_pc    = p;
  endtask

  task automatic idle_inputs();
    wwd_valid = 1'b0;
    step      = 1'b0;
    clear_ovf = 1'b0;
  endtask

  task automatic test_reset();
    reset_cpu_n = 1'b0;
    tick(); tick();
    checks++;
    if ({disp_valid, disp_data, disp_pc, count, cpu_stall, overflow} !== 30'd0) begin
      errors++;
      $display("FAIL reset_state got v=%b d=%h p=%h c=%0d s=%b o=%b want all zero",
               disp_valid, disp_data, disp_pc, count, cpu_stall, overflow);
    end
    reset_cpu_n = 1'b1;
    tick();
  endtask

  task automatic test_auto_single();
    auto_mode = 1'b1;
    drive_push(16'h0003, 8'h07);
    tick(); idle_inputs();
    checks++;
    if ({disp_valid, count} !== {1'b0, 3'd1}) begin
      errors++;
      $display("FAIL auto_n1 got v=%b c=%0d want v=0 c=1", disp_valid, count);
    end
    tick();
    checks++;
    if ({disp_valid, disp_data, disp_pc, count} !== {1'b1, 16'h0003, 8'h07, 3'd0}) begin
      errors++;
      $display("FAIL auto_n2 got v=%b d=%h p=%h c=%0d want v=1 d=0003 p=07 c=0",
               disp_valid, disp_data, disp_pc, count);
    end
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (disp_valid !== 1'b1) begin
      errors++;
      $display("FAIL auto_hold_last got v=%b want 1", disp_valid);
    end
    tick();
    checks++;
    if ({disp_valid, disp_data} !== {1'b0, 16'h0003}) begin
      errors++;
      $display("FAIL auto_release got v=%b d=%h want v=0 d=0003", disp_valid, disp_data);
    end
  endtask

  task automatic test_manual_fill();
    auto_mode = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive_push(16'(i), 8'(8'h10 + i));
      tick();
    end
    idle_inputs();
    checks++;
    if ({disp_valid, disp_data, disp_pc, count, cpu_stall, overflow} !==
        {1'b1, 16'h0001, 8'h11, 3'd4, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL fill got v=%b d=%h p=%h c=%0d s=%b o=%b want v=1 d=0001 p=11 c=4 s=1 o=0",
               disp_valid, disp_data, disp_pc, count, cpu_stall, overflow);
    end
  endtask

  task automatic test_overflow();
    drive_push(16'h0006, 8'h16);
    tick(); idle_inputs();
    checks++;
    if ({overflow, count, disp_data} !== {1'b1, 3'd4, 16'h0001}) begin
      errors++;
      $display("FAIL ovf_drop got o=%b c=%0d d=%h want o=1 c=4 d=0001", overflow, count, disp_data);
    end
    clear_ovf = 1'b1;
    tick(); idle_inputs();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear got o=%b want 0", overflow);
    end
    clear_ovf = 1'b1;
    drive_push(16'h0007, 8'h17);
    tick(); idle_inputs();
    checks++;
    if ({overflow, count} !== {1'b1, 3'd4}) begin
      errors++;
      $display("FAIL ovf_drop_wins got o=%b c=%0d want o=1 c=4", overflow, count);
    end
    clear_ovf = 1'b1;
    tick(); idle_inputs();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_reclear got o=%b want 0", overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_q[$];
    logic [15:0] exp_d;
    exp_q = '{16'h0003, 16'h0004, 16'h0005, 16'hBEEF};
    step = 1'b1;
    drive_push(16'hBEEF, 8'hEF);
    tick(); idle_inputs();
    checks++;
    if ({disp_valid, disp_data, count, cpu_stall} !== {1'b1, 16'h0002, 3'd4, 1'b1}) begin
      errors++;
      $display("FAIL full_push_pop got v=%b d=%h c=%0d s=%b want v=1 d=0002 c=4 s=1",
               disp_valid, disp_data, count, cpu_stall);
    end
    for (int i = 0; i < 4; i++) begin
      step = 1'b1;
      tick(); idle_inputs();
      exp_d = exp_q.pop_front();
      checks++;
      if ({disp_valid, disp_data, count} !== {1'b1, exp_d, 3'(3 - i)}) begin
        errors++;
        $display("FAIL step_order[%0d] got v=%b d=%h c=%0d want v=1 d=%h c=%0d",
                 i, disp_valid, disp_data, count, exp_d, 3 - i);
      end
    end
    step = 1'b1;
    tick(); idle_inputs();
    checks++;
    if ({disp_valid, disp_data, disp_pc} !== {1'b0, 16'hBEEF, 8'hEF}) begin
      errors++;
      $display("FAIL step_to_idle got v=%b d=%h p=%h want v=0 d=beef p=ef", disp_valid, disp_data, disp_pc);
    end
    step = 1'b1;
    tick(); idle_inputs();
    checks++;
    if ({disp_valid, count} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL step_in_idle got v=%b c=%0d want v=0 c=0", disp_valid, count);
    end
  endtask

  task automatic test_reset_mid_show();
    for (int i = 0; i < 4; i++) begin
      drive_push(16'(16'h0011 + i), 8'(8'h21 + i));
      tick();
    end
    idle_inputs();
    checks++;
    if ({disp_valid, disp_data, count} !== {1'b1, 16'h0011, 3'd3}) begin
      errors++;
      $display("FAIL pre_reset got v=%b d=%h c=%0d want v=1 d=0011 c=3", disp_valid, disp_data, count);
    end
    #2 reset_cpu_n = 1'b0;
    #1;
    checks++;
    if ({disp_valid, disp_data, disp_pc, count, cpu_stall, overflow} !== 30'd0) begin
      errors++;
      $display("FAIL async_reset got v=%b d=%h p=%h c=%0d s=%b o=%b want all zero",
               disp_valid, disp_data, disp_pc, count, cpu_stall, overflow);
    end
    tick();
    reset_cpu_n = 1'b1;
    tick();
    drive_push(16'h0055, 8'h66);
    tick(); idle_inputs();
    tick();
    checks++;
    if ({disp_valid, disp_data, disp_pc, count} !== {1'b1, 16'h0055, 8'h66, 3'd0}) begin
      errors++;
      $display("FAIL post_reset_latency got v=%b d=%h p=%h c=%0d want v=1 d=0055 p=66 c=0",
               disp_valid, disp_data, disp_pc, count);
    end
  endtask

  task automatic test_step_with_push_empty();
    step = 1'b1;
    drive_push(16'h0077, 8'h78);
    tick(); idle_inputs();
    checks++;
    if ({disp_valid, disp_data, count} !== {1'b0, 16'h0055, 3'd1}) begin
      errors++;
      $display("FAIL step_push_idle got v=%b d=%h c=%0d want v=0 d=0055 c=1", disp_valid, disp_data, count);
    end
    tick();
    checks++;
    if ({disp_valid, disp_data, disp_pc, count} !== {1'b1, 16'h0077, 8'h78, 3'd0}) begin
      errors++;
      $display("FAIL step_push_load got v=%b d=%h p=%h c=%0d want v=1 d=0077 p=78 c=0",
               disp_valid, disp_data, disp_pc, count);
    end
    step = 1'b1;
    tick(); idle_inputs();
  endtask

  task automatic test_wrap();
    auto_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_push(16'(16'h0100 + i), 8'(8'h80 + i));
      tick(); idle_inputs();
      tick();
      checks++;
      if ({disp_valid, disp_data, disp_pc} !== {1'b1, 16'(16'h0100 + i), 8'(8'h80 + i)}) begin
        errors++;
        $display("FAIL wrap[%0d] got v=%b d=%h p=%h want v=1 d=%h p=%h",
                 i, disp_valid, disp_data, disp_pc, 16'(16'h0100 + i), 8'(8'h80 + i));
      end
      for (int j = 0; j < 8; j++) tick();
      checks++;
      if (disp_valid !== 1'b0) begin
        errors++;
        $display("FAIL wrap_release[%0d] got v=%b want 0", i, disp_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_auto_single();
    test_manual_fill();
    test_overflow();
    test_back_to_back();
    test_reset_mid_show();
    test_step_with_push_empty();
    test_wrap();
    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
